// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the dual-clock FIFO: synchronizes the write pointer,
// issues memory reads and hides the 1-cycle read latency behind a 2-entry stream buffer.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    wptr_gray_async,
  input  logic [DATA_WIDTH-1:0] r_data_mem,
  output logic                  r_en,
  output logic [PTR_WIDTH:0]    read_addr,
  output logic [PTR_WIDTH:0]    rptr_gray,
  output logic                  rempty,
  output logic [PTR_WIDTH:0]    rd_level,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  logic [PTR_WIDTH:0]    wq1, wq2;
  logic [PTR_WIDTH:0]    wbin_s;
  logic [PTR_WIDTH:0]    rbin, next_rbin;
  logic                  inflight;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head_q, tail_q;
  logic                  pop;
  logic [2:0]            occ;

  always_comb begin
    wbin_s = '0;
    for (int unsigned i = 0; i <= PTR_WIDTH; i++) begin
      wbin_s[i] = ^(wq2 >> i);
    end
  end

  assign rempty    = (rbin == wbin_s);
  assign rd_level  = wbin_s - rbin;
  assign read_addr = {1'b0, rbin[PTR_WIDTH-1:0]};
  assign m_valid   = (buf_cnt != 2'd0);
  assign m_data    = head_q;
  assign pop       = m_valid & m_ready;

  // Occupancy counts words buffered plus the one in flight, net of this cycle's pop,
  // so a read is only issued when its data is guaranteed a buffer slot.
  assign occ       = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign r_en      = rrst_n & ~rempty & (occ < 3'd2);
  assign next_rbin = rbin + {{PTR_WIDTH{1'b0}}, r_en};

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      wq1       <= '0;
      wq2       <= '0;
      rbin      <= '0;
      rptr_gray <= '0;
      inflight  <= 1'b0;
      buf_cnt   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      wq1       <= wptr_gray_async;
      wq2       <= wq1;
      rbin      <= next_rbin;
      rptr_gray <= next_rbin ^ (next_rbin >> 1);
      inflight  <= r_en;
      case ({inflight, pop})
        2'b10: begin
          if (buf_cnt == 2'd0) head_q <= r_data_mem;
          else                 tail_q <= r_data_mem;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            head_q <= r_data_mem;
          end else begin
            head_q <= tail_q;
            tail_q <= r_data_mem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
